// File: rtl/bp_pht_if.sv
// Bundles the signals between the pattern history table and its two neighbours,
// the fetch PC generator and the execute-stage branch resolution.
//   slave  : the PHT (bp_pht_array)
//   master : the fetch/execute side that drives lookups, updates and flush
// Signals:
//   flush_i      restart the init sweep and clear the history
//   pred_req_i   lookup request;  pred_pc_i  lookup PC
//   pred_ready_o table initialised; lookups are accepted
//   pred_valid_o prediction valid, one cycle after an accepted request
//   pred_taken_o predicted direction;  pred_cnt_o  raw counter value
//   pred_idx_o   table index used; execute hands it back on update
//   upd_valid_i  resolved-branch update;  upd_idx_i/upd_taken_i  target and direction
//   ghr_o        current global history
interface bp_pht_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 2,
    parameter int unsigned IDX_W = 8,
    parameter int unsigned GHR_W = 8
);
    logic             flush_i;
    logic             pred_req_i;
    logic [XLEN-1:0]  pred_pc_i;
    logic             pred_ready_o;
    logic             pred_valid_o;
    logic             pred_taken_o;
    logic [CNT_W-1:0] pred_cnt_o;
    logic [IDX_W-1:0] pred_idx_o;
    logic             upd_valid_i;
    logic [IDX_W-1:0] upd_idx_i;
    logic             upd_taken_i;
    logic [GHR_W-1:0] ghr_o;

    modport slave (
        input  flush_i, pred_req_i, pred_pc_i, upd_valid_i, upd_idx_i, upd_taken_i,
        output pred_ready_o, pred_valid_o, pred_taken_o, pred_cnt_o, pred_idx_o, ghr_o
    );

    modport master (
        output flush_i, pred_req_i, pred_pc_i, upd_valid_i, upd_idx_i, upd_taken_i,
        input  pred_ready_o, pred_valid_o, pred_taken_o, pred_cnt_o, pred_idx_o, ghr_o
    );
endinterface

// File: rtl/bp_pht_array.sv
// Gshare pattern history table: 2^IDX_W saturating counters of CNT_W bits,
// indexed by PC[PC_LSB +: IDX_W] XOR the global history. Lookups return a
// registered prediction one cycle later; execute updates are applied in READY.
// After reset or flush an init sweep writes weakly-not-taken into every entry.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  bp_pht_if.slave (lookup, update, flush, history)
module bp_pht_array #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned IDX_W  = 8,
    parameter int unsigned GHR_W  = 8,
    parameter int unsigned PC_LSB = 2
) (
    input  logic   clk,
    input  logic   rst,
    bp_pht_if.slave bus
);
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] WNT      = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {INIT, READY} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             taken_q, taken_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [CNT_W-1:0] table_q [DEPTH];

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [CNT_W-1:0] wr_data;

    logic [IDX_W-1:0] lkp_idx;
    logic [CNT_W-1:0] lkp_cnt;
    logic [CNT_W-1:0] upd_old;
    logic [CNT_W-1:0] upd_new;
    logic [GHR_W-1:0] ghr_shift;
    logic             unused_pc_bits;

    // Only the index slice of the PC is meaningful here.
    assign unused_pc_bits = ^bus.pred_pc_i;

    // Gshare index uses the pre-edge history.
    assign lkp_idx = bus.pred_pc_i[PC_LSB +: IDX_W] ^ IDX_W'(ghr_q);
    assign lkp_cnt = table_q[lkp_idx];

    // Saturating step of the entry being resolved.
    assign upd_old = table_q[bus.upd_idx_i];
    always_comb begin
        upd_new = upd_old;
        if (bus.upd_taken_i) begin
            if (upd_old != CNT_MAX) upd_new = upd_old + CNT_W'(1);
        end else begin
            if (upd_old != '0) upd_new = upd_old - CNT_W'(1);
        end
    end

    // Truncating {ghr, taken} keeps the low GHR_W bits, which also covers GHR_W == 1.
    assign ghr_shift = GHR_W'({ghr_q, bus.upd_taken_i});

    // Next-state, table write port and registered-output values.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        valid_d = 1'b0;
        taken_d = taken_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        wr_data = WNT;

        if (bus.flush_i) begin
            state_d = INIT;
            ptr_d   = '0;
            ghr_d   = '0;
        end else begin
            case (state_q)
                INIT: begin
                    wr_en = 1'b1;
                    if (ptr_q == LAST_IDX) begin
                        state_d = READY;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + IDX_W'(1);
                    end
                end
                READY: begin
                    // Reads come from the pre-edge table, so a colliding update is not seen.
                    if (bus.pred_req_i) begin
                        valid_d = 1'b1;
                        cnt_d   = lkp_cnt;
                        taken_d = lkp_cnt[CNT_W-1];
                        idx_d   = lkp_idx;
                    end
                    if (bus.upd_valid_i) begin
                        wr_en   = 1'b1;
                        wr_idx  = bus.upd_idx_i;
                        wr_data = upd_new;
                        ghr_d   = ghr_shift;
                    end
                end
                default: begin
                    state_d = INIT;
                    ptr_d   = '0;
                end
            endcase
        end

        ready_d = (state_d == READY);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Counter storage has no reset; the init sweep defines it.
    always_ff @(posedge clk) begin
        if (wr_en) table_q[wr_idx] <= wr_data;
    end

    assign bus.pred_ready_o = ready_q;
    assign bus.pred_valid_o = valid_q;
    assign bus.pred_taken_o = taken_q;
    assign bus.pred_cnt_o   = cnt_q;
    assign bus.pred_idx_o   = idx_q;
    assign bus.ghr_o        = ghr_q;
endmodule

// File: tb/tb_bp_pht_array.sv
// Directed bench for bp_pht_array: dut_a uses CNT_W=2, dut_b uses CNT_W=3,
// both with IDX_W=4, GHR_W=4, PC_LSB=2.
module tb_bp_pht_array;
    localparam int XLEN   = 64;
    localparam int IDX_W  = 4;
    localparam int GHR_W  = 4;
    localparam int PC_LSB = 2;
    localparam int DEPTH  = 16;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   errors = 0;
    int   checks = 0;
    logic [3:0] ghr_a;
    logic [3:0] ghr_b;

    bp_pht_if #(.XLEN(XLEN), .CNT_W(2), .IDX_W(IDX_W), .GHR_W(GHR_W)) ifa ();
    bp_pht_if #(.XLEN(XLEN), .CNT_W(3), .IDX_W(IDX_W), .GHR_W(GHR_W)) ifb ();

    bp_pht_array #(.XLEN(XLEN), .CNT_W(2), .IDX_W(IDX_W), .GHR_W(GHR_W), .PC_LSB(PC_LSB))
        dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    bp_pht_array #(.XLEN(XLEN), .CNT_W(3), .IDX_W(IDX_W), .GHR_W(GHR_W), .PC_LSB(PC_LSB))
        dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ifa.flush_i = 0; ifa.pred_req_i = 0; ifa.pred_pc_i = '0;
        ifa.upd_valid_i = 0; ifa.upd_idx_i = '0; ifa.upd_taken_i = 0;
    endtask

    task automatic idle_b();
        ifb.flush_i = 0; ifb.pred_req_i = 0; ifb.pred_pc_i = '0;
        ifb.upd_valid_i = 0; ifb.upd_idx_i = '0; ifb.upd_taken_i = 0;
    endtask

    task automatic upd_a(input logic [3:0] idx, input logic t);
        ifa.upd_valid_i = 1; ifa.upd_idx_i = idx; ifa.upd_taken_i = t;
        tick();
        ifa.upd_valid_i = 0;
        ghr_a = {ghr_a[2:0], t};
    endtask

    task automatic upd_b(input logic [3:0] idx, input logic t);
        ifb.upd_valid_i = 1; ifb.upd_idx_i = idx; ifb.upd_taken_i = t;
        tick();
        ifb.upd_valid_i = 0;
        ghr_b = {ghr_b[2:0], t};
    endtask

    // Lookup aimed at table index idx given the expected history.
    task automatic look_a(input logic [3:0] idx);
        ifa.pred_req_i = 1;
        ifa.pred_pc_i  = XLEN'(idx ^ ghr_a) << PC_LSB;
        tick();
        ifa.pred_req_i = 0;
    endtask

    task automatic look_b(input logic [3:0] idx);
        ifb.pred_req_i = 1;
        ifb.pred_pc_i  = XLEN'(idx ^ ghr_b) << PC_LSB;
        tick();
        ifb.pred_req_i = 0;
    endtask

    task automatic test_reset();
        logic exp_r;
        rst_a = 1; rst_b = 1;
        idle_a(); idle_b();
        tick(); tick();
        checks++;
        if ({ifa.pred_ready_o, ifa.pred_valid_o, ifa.pred_taken_o, ifa.pred_cnt_o,
             ifa.pred_idx_o, ifa.ghr_o} !== 13'h0) begin
            errors++; $display("FAIL reset_a_outputs: got ready=%b valid=%b taken=%b cnt=%h idx=%h ghr=%h want all 0",
                ifa.pred_ready_o, ifa.pred_valid_o, ifa.pred_taken_o, ifa.pred_cnt_o, ifa.pred_idx_o, ifa.ghr_o);
        end
        checks++;
        if ({ifb.pred_ready_o, ifb.pred_valid_o, ifb.pred_taken_o, ifb.pred_cnt_o,
             ifb.pred_idx_o, ifb.ghr_o} !== 14'h0) begin
            errors++; $display("FAIL reset_b_outputs: got ready=%b valid=%b cnt=%h ghr=%h want all 0",
                ifb.pred_ready_o, ifb.pred_valid_o, ifb.pred_cnt_o, ifb.ghr_o);
        end
        rst_a = 0; rst_b = 0;
        ghr_a = 0; ghr_b = 0;
        for (int e = 1; e <= DEPTH; e++) begin
            tick();
            exp_r = (e == DEPTH);
            checks++;
            if (ifa.pred_ready_o !== exp_r) begin
                errors++; $display("FAIL init_ready_a edge %0d: got %b want %b", e, ifa.pred_ready_o, exp_r);
            end
            checks++;
            if (ifb.pred_ready_o !== exp_r) begin
                errors++; $display("FAIL init_ready_b edge %0d: got %b want %b", e, ifb.pred_ready_o, exp_r);
            end
        end
    endtask

    // Back-to-back lookups of every index; all should read weakly-not-taken.
    task automatic test_all_wnt(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            ifa.pred_req_i = 1;
            ifa.pred_pc_i  = XLEN'(i) << PC_LSB;
            tick();
            checks++;
            if (ifa.pred_valid_o !== 1'b1 || ifa.pred_cnt_o !== 2'b01 || ifa.pred_taken_o !== 1'b0
                || ifa.pred_idx_o !== 4'(i)) begin
                errors++; $display("FAIL %s idx %0d: got valid=%b cnt=%b taken=%b idx=%h want valid=1 cnt=01 taken=0 idx=%h",
                    tag, i, ifa.pred_valid_o, ifa.pred_cnt_o, ifa.pred_taken_o, ifa.pred_idx_o, 4'(i));
            end
        end
        ifa.pred_req_i = 0;
        tick();
        checks++;
        if (ifa.pred_valid_o !== 1'b0) begin
            errors++; $display("FAIL %s valid_drop: got %b want 0", tag, ifa.pred_valid_o);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] up_exp [3];
        logic [1:0] dn_exp [4];
        up_exp[0] = 2'b10; up_exp[1] = 2'b11; up_exp[2] = 2'b11;
        dn_exp[0] = 2'b10; dn_exp[1] = 2'b01; dn_exp[2] = 2'b00; dn_exp[3] = 2'b00;
        for (int k = 0; k < 3; k++) begin
            upd_a(4'd5, 1'b1);
            look_a(4'd5);
            checks++;
            if (ifa.pred_cnt_o !== up_exp[k] || ifa.pred_taken_o !== up_exp[k][1]
                || ifa.pred_idx_o !== 4'd5 || ifa.ghr_o !== ghr_a) begin
                errors++; $display("FAIL sat_up step %0d: got cnt=%b taken=%b idx=%h ghr=%h want cnt=%b taken=%b idx=5 ghr=%h",
                    k, ifa.pred_cnt_o, ifa.pred_taken_o, ifa.pred_idx_o, ifa.ghr_o, up_exp[k], up_exp[k][1], ghr_a);
            end
        end
        for (int k = 0; k < 4; k++) begin
            upd_a(4'd5, 1'b0);
            look_a(4'd5);
            checks++;
            if (ifa.pred_cnt_o !== dn_exp[k] || ifa.pred_taken_o !== dn_exp[k][1]
                || ifa.pred_idx_o !== 4'd5 || ifa.ghr_o !== ghr_a) begin
                errors++; $display("FAIL sat_down step %0d: got cnt=%b taken=%b idx=%h ghr=%h want cnt=%b taken=%b idx=5 ghr=%h",
                    k, ifa.pred_cnt_o, ifa.pred_taken_o, ifa.pred_idx_o, ifa.ghr_o, dn_exp[k], dn_exp[k][1], ghr_a);
            end
        end
    endtask

    task automatic test_history();
        upd_a(4'd9, 1'b1);
        upd_a(4'd9, 1'b0);
        upd_a(4'd9, 1'b1);
        upd_a(4'd9, 1'b1);
        checks++;
        if (ifa.ghr_o !== 4'hB) begin
            errors++; $display("FAIL ghr_pattern: got %h want b", ifa.ghr_o);
        end
        ifa.pred_req_i = 1;
        ifa.pred_pc_i  = 64'h40;
        tick();
        ifa.pred_req_i = 0;
        checks++;
        if (ifa.pred_valid_o !== 1'b1 || ifa.pred_idx_o !== 4'hB || ifa.pred_cnt_o !== 2'b01) begin
            errors++; $display("FAIL ghr_index: got valid=%b idx=%h cnt=%b want valid=1 idx=b cnt=01",
                ifa.pred_valid_o, ifa.pred_idx_o, ifa.pred_cnt_o);
        end
        look_a(4'd9);
        checks++;
        if (ifa.pred_cnt_o !== 2'b11 || ifa.pred_idx_o !== 4'd9) begin
            errors++; $display("FAIL ghr_idx9_value: got cnt=%b idx=%h want cnt=11 idx=9", ifa.pred_cnt_o, ifa.pred_idx_o);
        end
    endtask

    task automatic test_back_to_back();
        upd_a(4'd7, 1'b1);
        upd_a(4'd7, 1'b1);
        look_a(4'd7);
        checks++;
        if (ifa.pred_cnt_o !== 2'b11 || ifa.pred_taken_o !== 1'b1) begin
            errors++; $display("FAIL b2b_update: got cnt=%b taken=%b want cnt=11 taken=1", ifa.pred_cnt_o, ifa.pred_taken_o);
        end
        tick();
        checks++;
        if (ifa.pred_valid_o !== 1'b0) begin
            errors++; $display("FAIL b2b_no_hold: got valid=%b want 0", ifa.pred_valid_o);
        end
    endtask

    task automatic test_collision();
        upd_a(4'd3, 1'b1);
        ifa.pred_req_i  = 1;
        ifa.pred_pc_i   = XLEN'(4'd3 ^ ghr_a) << PC_LSB;
        ifa.upd_valid_i = 1; ifa.upd_idx_i = 4'd3; ifa.upd_taken_i = 0;
        tick();
        idle_a();
        ghr_a = {ghr_a[2:0], 1'b0};
        checks++;
        if (ifa.pred_valid_o !== 1'b1 || ifa.pred_idx_o !== 4'd3 || ifa.pred_cnt_o !== 2'b10
            || ifa.pred_taken_o !== 1'b1) begin
            errors++; $display("FAIL collision_read: got valid=%b idx=%h cnt=%b taken=%b want valid=1 idx=3 cnt=10 taken=1",
                ifa.pred_valid_o, ifa.pred_idx_o, ifa.pred_cnt_o, ifa.pred_taken_o);
        end
        look_a(4'd3);
        checks++;
        if (ifa.pred_cnt_o !== 2'b01 || ifa.pred_idx_o !== 4'd3) begin
            errors++; $display("FAIL collision_after: got cnt=%b idx=%h want cnt=01 idx=3", ifa.pred_cnt_o, ifa.pred_idx_o);
        end
    endtask

    task automatic test_flush();
        logic exp_r;
        upd_a(4'd2, 1'b1);
        ifa.flush_i = 1;
        ifa.pred_req_i = 1; ifa.pred_pc_i = 64'h8;
        ifa.upd_valid_i = 1; ifa.upd_idx_i = 4'd2; ifa.upd_taken_i = 1;
        tick();
        ifa.flush_i = 0;
        ghr_a = 0;
        checks++;
        if (ifa.pred_ready_o !== 1'b0 || ifa.pred_valid_o !== 1'b0 || ifa.ghr_o !== 4'h0) begin
            errors++; $display("FAIL flush_edge: got ready=%b valid=%b ghr=%h want ready=0 valid=0 ghr=0",
                ifa.pred_ready_o, ifa.pred_valid_o, ifa.ghr_o);
        end
        // Requests and updates held through the sweep must be dropped.
        ifa.pred_pc_i = '0; ifa.upd_idx_i = 4'd0;
        for (int e = 1; e <= DEPTH; e++) begin
            tick();
            exp_r = (e == DEPTH);
            checks++;
            if (ifa.pred_ready_o !== exp_r || ifa.pred_valid_o !== 1'b0) begin
                errors++; $display("FAIL flush_sweep edge %0d: got ready=%b valid=%b want ready=%b valid=0",
                    e, ifa.pred_ready_o, ifa.pred_valid_o, exp_r);
            end
            if (e == DEPTH) idle_a();
        end
        checks++;
        if (ifa.ghr_o !== 4'h0) begin
            errors++; $display("FAIL flush_ghr: got %h want 0", ifa.ghr_o);
        end
        test_all_wnt("flush_wnt");
    endtask

    task automatic test_cnt3();
        logic [2:0] exp3 [5];
        logic exp_r;
        exp3[0] = 3'b100; exp3[1] = 3'b101; exp3[2] = 3'b110; exp3[3] = 3'b111; exp3[4] = 3'b111;
        look_b(4'd4);
        checks++;
        if (ifb.pred_cnt_o !== 3'b011 || ifb.pred_taken_o !== 1'b0) begin
            errors++; $display("FAIL cnt3_wnt: got cnt=%b taken=%b want cnt=011 taken=0", ifb.pred_cnt_o, ifb.pred_taken_o);
        end
        for (int k = 0; k < 5; k++) begin
            upd_b(4'd4, 1'b1);
            look_b(4'd4);
            checks++;
            if (ifb.pred_cnt_o !== exp3[k] || ifb.pred_taken_o !== 1'b1 || ifb.pred_idx_o !== 4'd4) begin
                errors++; $display("FAIL cnt3_up step %0d: got cnt=%b taken=%b idx=%h want cnt=%b taken=1 idx=4",
                    k, ifb.pred_cnt_o, ifb.pred_taken_o, ifb.pred_idx_o, exp3[k]);
            end
        end
        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_b = 1;
        #1;
        checks++;
        if ({ifb.pred_ready_o, ifb.pred_valid_o, ifb.pred_taken_o, ifb.pred_cnt_o,
             ifb.pred_idx_o, ifb.ghr_o} !== 14'h0) begin
            errors++; $display("FAIL cnt3_async_rst: got ready=%b valid=%b taken=%b cnt=%b idx=%h ghr=%h want all 0",
                ifb.pred_ready_o, ifb.pred_valid_o, ifb.pred_taken_o, ifb.pred_cnt_o, ifb.pred_idx_o, ifb.ghr_o);
        end
        tick(); tick();
        rst_b = 0;
        ghr_b = 0;
        for (int e = 1; e <= DEPTH; e++) begin
            tick();
            exp_r = (e == DEPTH);
            checks++;
            if (ifb.pred_ready_o !== exp_r) begin
                errors++; $display("FAIL cnt3_resweep edge %0d: got %b want %b", e, ifb.pred_ready_o, exp_r);
            end
        end
        look_b(4'd4);
        checks++;
        if (ifb.pred_cnt_o !== 3'b011 || ifb.pred_valid_o !== 1'b1) begin
            errors++; $display("FAIL cnt3_after_rst: got cnt=%b valid=%b want cnt=011 valid=1", ifb.pred_cnt_o, ifb.pred_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_all_wnt("init_wnt");
        test_saturation();
        test_history();
        test_back_to_back();
        test_collision();
        test_flush();
        test_cnt3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
